// File: rtl/ddr2_host_if.sv
// ---------------------------------------------------------------------------
// ddr2_host_if
//
// Host-side front end for ddr2_controller. Host requests arrive over a
// valid/ready handshake and are re-issued as one-cycle command pulses on the
// controller's CMD/SZ/OP/ADDR/DIN inputs. Block writes take word 0 with the
// request and words 1..N-1 over a separate WDATA valid/ready stream.
// Acceptance is throttled by the controller's NOTFULL and FILLCOUNT.
//
// Parameters
//   FIFO_HI  FILLCOUNT threshold; the data FIFO has space when FILLCOUNT <= FIFO_HI
//   CNT_W    width of the block-write word counter (must hold 31)
//
// Ports
//   CLK, RESET                 clock, synchronous active-high reset
//   REQ_VALID / REQ_READY      host request handshake (REQ_READY combinational)
//   REQ_CMD/SZ/OP/ADDR/DIN     request fields; REQ_DIN is word 0 of a block write
//   REQ_FETCHING               FETCHING hint, delayed one cycle to FETCHING
//   WDATA_VALID / WDATA_READY  block-write word handshake (WDATA_READY combinational)
//   WDATA                      block-write words 1..N-1
//   READY, NOTFULL, FILLCOUNT  controller status / flow control
//   CMD/SZ/OP/ADDR/DIN         registered command to the controller
//   FETCHING                   registered FETCHING to the controller
//
// Optional feature (macro DDR2_HOST_IF_STATS_EN)
//   STAT_CMDS    saturating count of non-NOP commands issued
//   STAT_STALLS  saturating count of stalled request / write-word cycles
// ---------------------------------------------------------------------------
module ddr2_host_if #(
  parameter int FIFO_HI = 63,
  parameter int CNT_W   = 6
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [2:0]  REQ_CMD,
  input  logic [1:0]  REQ_SZ,
  input  logic [2:0]  REQ_OP,
  input  logic [24:0] REQ_ADDR,
  input  logic [15:0] REQ_DIN,
  input  logic        REQ_FETCHING,
  input  logic        WDATA_VALID,
  output logic        WDATA_READY,
  input  logic [15:0] WDATA,
  input  logic        READY,
  input  logic        NOTFULL,
  input  logic [6:0]  FILLCOUNT,
  output logic [2:0]  CMD,
  output logic [1:0]  SZ,
  output logic [2:0]  OP,
  output logic [24:0] ADDR,
  output logic [15:0] DIN,
  output logic        FETCHING
`ifdef DDR2_HOST_IF_STATS_EN
  ,
  output logic [15:0] STAT_CMDS,
  output logic [15:0] STAT_STALLS
`endif
);

  localparam logic [1:0] ST_WAIT_RDY = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_BLKWR    = 2'd2;

  localparam logic [2:0] C_NOP = 3'd0;
  localparam logic [2:0] C_SCR = 3'd1;
  localparam logic [2:0] C_SCW = 3'd2;
  localparam logic [2:0] C_BLR = 3'd3;
  localparam logic [2:0] C_BLW = 3'd4;
  localparam logic [2:0] C_ATR = 3'd5;
  localparam logic [2:0] C_ATW = 3'd6;
  localparam logic [2:0] C_NP7 = 3'd7;

  localparam logic [6:0] FIFO_HI_W = 7'(FIFO_HI);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       cmd_q, cmd_d;
  logic [1:0]       sz_q, sz_d;
  logic [2:0]       op_q, op_d;
  logic [24:0]      addr_q, addr_d;
  logic [15:0]      din_q, din_d;
  logic             fetching_q, fetching_d;

  logic dspace;
  logic cspace;
  logic cmd_ok;
  logic req_ready;
  logic req_fire;
  logic wdata_ready;
  logic wdata_fire;
  logic is_nop;

  assign dspace = (FILLCOUNT <= FIFO_HI_W);
  assign cspace = NOTFULL;
  assign is_nop = (REQ_CMD == C_NOP) || (REQ_CMD == C_NP7);

  // Acceptance depends on the command class: NOPs never touch the
  // controller, reads only need command space, anything that carries data
  // also needs data-FIFO space.
  always_comb begin
    cmd_ok = 1'b0;
    case (REQ_CMD)
      C_NOP, C_NP7: cmd_ok = 1'b1;
      C_SCR, C_BLR: cmd_ok = cspace;
      default:      cmd_ok = cspace && dspace;
    endcase
  end

  assign req_ready   = (state_q == ST_RUN) && cmd_ok;
  assign req_fire    = REQ_VALID && req_ready;
  assign wdata_ready = (state_q == ST_BLKWR) && dspace;
  assign wdata_fire  = WDATA_VALID && wdata_ready;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case/if tree can leave one unassigned and infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_d      = C_NOP;
    sz_d       = sz_q;
    op_d       = op_q;
    addr_d     = addr_q;
    din_d      = din_q;
    fetching_d = REQ_FETCHING;

    if (req_fire) begin
      cmd_d  = is_nop ? C_NOP : REQ_CMD;
      sz_d   = (REQ_CMD >= C_BLR && REQ_CMD <= C_ATW) ? REQ_SZ : 2'd0;
      op_d   = (REQ_CMD == C_ATR || REQ_CMD == C_ATW) ? REQ_OP : 3'd0;
      addr_d = REQ_ADDR;
      din_d  = REQ_DIN;
    end

    if (wdata_fire) begin
      din_d = WDATA;
      cnt_d = cnt_q - CNT_W'(1);
    end

    case (state_q)
      ST_WAIT_RDY: begin
        if (READY) state_d = ST_RUN;
      end
      ST_RUN: begin
        // A burst start wins over READY dropping; the burst must complete.
        if (req_fire && REQ_CMD == C_BLW) begin
          cnt_d   = CNT_W'({REQ_SZ, 3'b111});   // 8*(SZ+1)-1 words still to come
          state_d = ST_BLKWR;
        end else if (!READY) begin
          state_d = ST_WAIT_RDY;
        end
      end
      ST_BLKWR: begin
        if (wdata_fire && cnt_q == CNT_W'(1)) state_d = ST_RUN;
      end
      default: state_d = ST_WAIT_RDY;
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of order.
    if (RESET) begin
      state_q    <= ST_WAIT_RDY;
      cnt_q      <= '0;
      cmd_q      <= '0;
      sz_q       <= '0;
      op_q       <= '0;
      addr_q     <= '0;
      din_q      <= '0;
      fetching_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      sz_q       <= sz_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      fetching_q <= fetching_d;
    end
  end

  assign REQ_READY   = req_ready;
  assign WDATA_READY = wdata_ready;
  assign CMD         = cmd_q;
  assign SZ          = sz_q;
  assign OP          = op_q;
  assign ADDR        = addr_q;
  assign DIN         = din_q;
  assign FETCHING    = fetching_q;

`ifdef DDR2_HOST_IF_STATS_EN
  logic [15:0] stat_cmds_q, stat_cmds_d;
  logic [15:0] stat_stalls_q, stat_stalls_d;
  logic        stall_now;

  assign stall_now = ((state_q == ST_RUN)   && REQ_VALID   && !req_ready) ||
                     ((state_q == ST_BLKWR) && WDATA_VALID && !wdata_ready);

  always_comb begin
    stat_cmds_d   = stat_cmds_q;
    stat_stalls_d = stat_stalls_q;
    if (req_fire && !is_nop && stat_cmds_q != 16'hFFFF)
      stat_cmds_d = stat_cmds_q + 16'd1;
    if (stall_now && stat_stalls_q != 16'hFFFF)
      stat_stalls_d = stat_stalls_q + 16'd1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      stat_cmds_q   <= '0;
      stat_stalls_q <= '0;
    end else begin
      stat_cmds_q   <= stat_cmds_d;
      stat_stalls_q <= stat_stalls_d;
    end
  end

  assign STAT_CMDS   = stat_cmds_q;
  assign STAT_STALLS = stat_stalls_q;
`endif

endmodule
